// File: rtl/dbg_trace_buf_if.sv
// Decode-event input and trace read-port bundle for dbg_trace_buf.
interface dbg_trace_buf_if;
   logic        ev_valid;
   logic [63:0] ev_pc;
   logic [31:0] ev_inst;
   logic [4:0]  ev_rd;
   logic [4:0]  ev_cause;
   logic [63:0] ev_tval;

   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic [4:0]  out_rd;
   logic [4:0]  out_cause;
   logic [63:0] out_tval;

   // decode side / debug host
   modport master (
      output ev_valid, ev_pc, ev_inst, ev_rd, ev_cause, ev_tval, out_ready,
      input  out_valid, out_pc, out_inst, out_rd, out_cause, out_tval
   );

   // trace buffer
   modport slave (
      input  ev_valid, ev_pc, ev_inst, ev_rd, ev_cause, ev_tval, out_ready,
      output out_valid, out_pc, out_inst, out_rd, out_cause, out_tval
   );
endinterface

// File: rtl/dbg_trace_buf.sv
// Decode-stage trace capture buffer: circular history of decode events,
// trigger on exception cause or PC match, POST_CNT further events, then
// drain oldest-first over a valid/ready port.
module dbg_trace_buf #(
   parameter int DEPTH    = 16,
   parameter int POST_CNT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   arm,
   input  logic                   trig_pc_en,
   input  logic [63:0]            trig_pc,
   dbg_trace_buf_if.slave         bus,
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] count,
   output logic                   triggered,
   output logic                   wrapped
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [4:0]  cause;
      logic [63:0] tval;
   } entry_t;

   typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, POST = 2'd2, READOUT = 2'd3} state_t;

   state_t        st, st_nxt;
   logic [PW-1:0] wr_ptr, rd_ptr, post_left;
   entry_t        mem [DEPTH];
   entry_t        wr_ent, rd_ent;
   logic          trig_hit, full;
   logic          wr_en, pop, clr, set_trig, load_post, load_rd;
   logic [CW-1:0] cnt_inc;
   logic [PW-1:0] rd_start;

   assign state    = st;
   assign trig_hit = bus.ev_valid &&
                     ((bus.ev_cause != 5'd0) || (trig_pc_en && (bus.ev_pc == trig_pc)));
   assign full     = (count == CW'(DEPTH));
   assign cnt_inc  = full ? count : count + CW'(1);
   // Oldest entry once the final write has landed; when full the low
   // count bits are zero, so this collapses to the next write slot.
   assign rd_start = wr_ptr + PW'(1) - cnt_inc[PW-1:0];
   assign wr_ent   = '{pc: bus.ev_pc, inst: bus.ev_inst, rd: bus.ev_rd,
                       cause: bus.ev_cause, tval: bus.ev_tval};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   // Next-state and datapath strobes
   always_comb begin
      st_nxt    = st;
      wr_en     = 1'b0;
      pop       = 1'b0;
      clr       = 1'b0;
      set_trig  = 1'b0;
      load_post = 1'b0;
      load_rd   = 1'b0;
      case (st)
         IDLE: begin
            if (arm) begin
               clr    = 1'b1;
               st_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            // arm beats a coincident event: the event is dropped
            if (arm) begin
               clr = 1'b1;
            end else if (bus.ev_valid) begin
               wr_en = 1'b1;
               if (trig_hit) begin
                  set_trig = 1'b1;
                  if (POST_CNT != 0) begin
                     load_post = 1'b1;
                     st_nxt    = POST;
                  end else begin
                     load_rd = 1'b1;
                     st_nxt  = READOUT;
                  end
               end
            end
         end
         POST: begin
            if (bus.ev_valid) begin
               wr_en = 1'b1;
               if (post_left == PW'(1)) begin
                  load_rd = 1'b1;
                  st_nxt  = READOUT;
               end
            end
         end
         READOUT: begin
            if (count == '0) begin
               st_nxt = IDLE;
            end else if (bus.out_ready) begin
               pop = 1'b1;
               if (count == CW'(1)) st_nxt = IDLE;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   // Pointers, occupancy and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         post_left <= '0;
         triggered <= 1'b0;
         wrapped   <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         post_left <= '0;
         triggered <= 1'b0;
         wrapped   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
            count  <= cnt_inc;
            if (full) wrapped <= 1'b1;
         end
         if (set_trig) triggered <= 1'b1;
         if (load_post)
            post_left <= PW'(POST_CNT);
         else if (wr_en && (st == POST))
            post_left <= post_left - PW'(1);
         if (load_rd) rd_ptr <= rd_start;
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            count  <= count - CW'(1);
         end
      end
   end

   // Trace storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_ent;
   end

   assign bus.out_valid = (st == READOUT) && (count != '0);
   assign rd_ent        = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.out_pc    = rd_ent.pc;
   assign bus.out_inst  = rd_ent.inst;
   assign bus.out_rd    = rd_ent.rd;
   assign bus.out_cause = rd_ent.cause;
   assign bus.out_tval  = rd_ent.tval;
endmodule

// File: doc/dbg_trace_buf.md
# dbg_trace_buf

Decode-stage trace capture buffer. While armed, it records every valid decode event (pc, inst, rd, cause, tval) into a circular buffer and watches for a trigger: an exception cause, or a match on a programmed PC. After the trigger it records a fixed number of further events, freezes, and drains the captured history oldest-first over a valid/ready read port. It sits beside the decode stage and feeds a debug host or a bench-side trace printer.

## Interface
- DEPTH, 16, entries in the buffer; power of two, at least 4
- POST_CNT, 4, events captured after the trigger event; range 0 to DEPTH-1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- arm  in  1  single-cycle pulse that starts a capture
- trig_pc_en  in  1  enables the PC-match trigger
- trig_pc  in  64  PC to match
- ev_valid  in  1  decode event valid this cycle
- ev_pc  in  64  event PC
- ev_inst  in  32  event instruction
- ev_rd  in  5  event destination register
- ev_cause  in  5  event exception cause; nonzero means exception
- ev_tval  in  64  event trap value
- out_valid  out  1  read entry valid
- out_ready  in  1  read consumer ready
- out_pc, out_inst, out_rd, out_cause, out_tval  out  64/32/5/5/64  read entry fields
- state  out  2  0=IDLE, 1=CAPTURE, 2=POST, 3=READOUT
- count  out  $clog2(DEPTH)+1  entries currently held
- triggered  out  1  a trigger has occurred since the last arm
- wrapped  out  1  at least one entry was overwritten since the last arm

## Operation
- **Trigger condition (trig_hit):** ev_valid && (ev_cause != 0 || (trig_pc_en && ev_pc == trig_pc)).
- **Write:** stores {pc, inst, rd, cause, tval} at wr_ptr, then wr_ptr = (wr_ptr+1) mod DEPTH.
  - count increments and saturates at DEPTH.
  - A write while count == DEPTH overwrites the oldest entry and sets wrapped.
- **IDLE**
  - Events are ignored.
  - arm: clears wr_ptr, rd_ptr, count, triggered and wrapped, then moves to CAPTURE.
- **CAPTURE**
  - Each ev_valid performs a write.
  - On trig_hit the trigger event is written and triggered is set.
  - If POST_CNT > 0: moves to POST with post_left = POST_CNT.
  - If POST_CNT == 0: moves to READOUT.
  - arm in CAPTURE restarts the capture (same clears as from IDLE) and stays in CAPTURE. When arm and ev_valid coincide, arm wins and the event is discarded.
- **POST**
  - Each ev_valid writes and decrements post_left.
  - The write that takes post_left to 0 moves the block to READOUT.
  - Further trig_hit events are written like any other event and do not re-trigger.
  - arm is ignored.
- **READOUT**
  - On entry, rd_ptr = (wr_ptr - count) mod DEPTH, which points at the oldest entry.
  - out_valid = (count != 0). out_* fields are mem[rd_ptr], driven combinationally from the register array.
  - On out_valid && out_ready: rd_ptr increments mod DEPTH and count decrements.
  - When count reaches 0, the block returns to IDLE on that edge.
  - ev_valid and arm are ignored.
- **Output gating:** out_* data are forced to 0 whenever out_valid = 0.
- **Pointer arithmetic:** pointers are $clog2(DEPTH) bits and wrap naturally. count is one bit wider.

## Timing
- **Reset values:** state=IDLE, wr_ptr=rd_ptr=0, count=0, post_left=0, triggered=0, wrapped=0, out_valid=0, all out_* data 0. The memory array is not reset.
- All state, pointer and flag updates occur on the clk rising edge. Reset is asynchronous.
- Event at edge T:
  - count, wrapped and triggered reflect it after T.
  - A trigger at T gives state=POST (or READOUT) after T.
- out_valid is high in the first cycle of READOUT.
- Readout throughput is one entry per cycle while out_ready is held high.
- out_* are stable while out_valid && !out_ready.
- An N-entry drain with out_ready held high takes N cycles; state=IDLE in the cycle after the last pop.
- Reset asserted mid-capture or mid-readout aborts immediately to reset values. A partially drained entry is lost.

## Test plan
- **Basic trigger (DEPTH=16, POST_CNT=4):** arm, then 3 events with pc 0x100, 0x104, 0x108 (cause 0), then an event with pc 0x10c and cause 2, then 4 more events. Required: state=READOUT, count=8, triggered=1, wrapped=0; readout yields pc 0x100..0x11c in order, out_cause=2 on the 4th entry; state=IDLE afterwards.
- **Wrap:** arm, then 20 events with pc 0x0, 0x4, ... 0x4c, with the 20th carrying cause 5 (POST_CNT=0). Required: wrapped=1, count=16; readout pcs 0x10..0x4c.
- **PC match:** trig_pc_en=1, trig_pc=0x2000, events at 0x1ffc and 0x2000, all cause 0, POST_CNT=4. Required: triggered=1 and state=POST after the 0x2000 event.
- **Backpressure:** in READOUT, toggle out_ready every other cycle. Required: no entry skipped or duplicated; out_* held while stalled.
- **Arm collisions:** arm coincident with ev_valid in CAPTURE gives count=0 after the edge. arm during POST or READOUT changes nothing.
- **Reset mid-readout:** after 3 of 8 entries popped, pulse rst_n low. Required: state=IDLE, count=0, out_valid=0 immediately.
